// File: rtl/mont_mul_defines.sv
// Shared LSU definitions for mont_mul: access sizes, operand selects, FSM states
// and the latched bus-transaction payload.
package mont_mul_defines;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    LSU_TYPE_WORD = 2'b00,
    LSU_TYPE_HALF = 2'b01,
    LSU_TYPE_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [1:0] {
    OPSEL_A   = 2'd0,
    OPSEL_B   = 2'd1,
    OPSEL_N   = 2'd2,
    OPSEL_RES = 2'd3
  } opsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        lane;
    logic [1:0]        size;
  } lsu_txn_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for a 32-bit data bus: store-side byte enables, write-data
// shift and misalign detect; load-side right-align and zero-extend.
module lsu_align
  import mont_mul_defines::*;
(
  input  logic [1:0]        req_lane,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [BE_W-1:0]   req_be_c,
  output logic [DATA_W-1:0] req_wdata_c,
  output logic              req_misalign_c,
  input  logic [1:0]        rsp_lane,
  input  logic [1:0]        rsp_size,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] rsp_rdata_c
);

  logic [DATA_W-1:0] rsp_shifted;

  // Unknown size code 2'b11 is handled as a word access.
  always_comb begin
    req_be_c       = '1;
    req_misalign_c = 1'b0;
    case (req_size)
      LSU_TYPE_HALF: begin
        req_be_c       = BE_W'(4'b0011) << req_lane;
        req_misalign_c = req_lane[0];
      end
      LSU_TYPE_BYTE: req_be_c = BE_W'(4'b0001) << req_lane;
      default:       req_misalign_c = (req_lane != 2'b00);
    endcase
  end

  assign req_wdata_c = req_wdata << {req_lane, 3'b000};
  assign rsp_shifted = rsp_rdata >> {rsp_lane, 3'b000};

  always_comb begin
    case (rsp_size)
      LSU_TYPE_HALF: rsp_rdata_c = DATA_W'(rsp_shifted[15:0]);
      LSU_TYPE_BYTE: rsp_rdata_c = DATA_W'(rsp_shifted[7:0]);
      default:       rsp_rdata_c = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mont_mul_lsu.sv
// Responder for mont_mul load/store requests: resolves base+offset addresses and
// runs one req/gnt/rvalid data-bus transaction per request, with timeout.
module mont_mul_lsu
  import mont_mul_defines::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  input  logic              lsu_ren,
  input  logic              lsu_wen,
  input  logic [1:0]        lsu_type,
  input  logic [31:0]       lsu_addr_offset,
  input  logic [1:0]        op_address_sel,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              data_req,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_we,
  output logic [3:0]        data_be,
  output logic [31:0]       data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [31:0]       data_rdata
);

  localparam int unsigned      TMO_W    = 32;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [DATA_W-1:0] base_q [4];
  logic [ADDR_W-1:0] addr_q, addr_d, req_addr;
  lsu_txn_t          txn_q, txn_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d, done_q, req_q;
  logic              tmo_hit;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_sh_c, rdata_ext_c;
  logic              misalign_c;

  assign req_addr = ADDR_W'(base_q[op_address_sel]) + ADDR_W'(lsu_addr_offset);
  assign tmo_hit  = (REQ_TIMEOUT != 0) && (tmo_q == TMO_LAST);

  lsu_align u_align (
    .req_lane       (req_addr[1:0]),
    .req_size       (lsu_type),
    .req_wdata      (lsu_wdata),
    .req_be_c       (be_c),
    .req_wdata_c    (wdata_sh_c),
    .req_misalign_c (misalign_c),
    .rsp_lane       (txn_q.lane),
    .rsp_size       (txn_q.size),
    .rsp_rdata      (data_rdata),
    .rsp_rdata_c    (rdata_ext_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) base_q[i] <= '0;
    end else if (cfg_we) begin
      base_q[cfg_sel] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    txn_d   = txn_q;
    tmo_d   = '0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_ren || lsu_wen) begin
          if (misalign_c) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ST_REQ;
            addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
            txn_d.we    = lsu_wen;
            txn_d.be    = be_c;
            txn_d.wdata = wdata_sh_c;
            txn_d.lane  = req_addr[1:0];
            txn_d.size  = lsu_type;
          end
        end
      end
      ST_REQ: begin
        tmo_d = tmo_q + 1'b1;
        if (data_gnt) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          tmo_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A response in the timeout cycle still completes the access.
        if (data_rvalid) begin
          state_d = ST_RESP;
          tmo_d   = '0;
          rdata_d = rdata_ext_c;
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          tmo_d   = '0;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      txn_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      txn_q   <= txn_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= (state_d == ST_RESP);
      req_q   <= (state_d == ST_REQ);
    end
  end

  assign lsu_done   = done_q;
  assign lsu_rdata  = rdata_q;
  assign lsu_err    = err_q;
  assign data_req   = req_q;
  assign data_addr  = addr_q;
  assign data_we    = txn_q.we;
  assign data_be    = txn_q.be;
  assign data_wdata = txn_q.wdata;

endmodule

// File: tb/tb_mont_mul_lsu.sv
// Directed bench for mont_mul_lsu with a small bus responder (programmable grant
// delay, one-cycle rvalid after grant).
module tb_mont_mul_lsu;
  import mont_mul_defines::*;

  logic        clk, rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        lsu_ren, lsu_wen;
  logic [1:0]  lsu_type;
  logic [31:0] lsu_addr_offset;
  logic [1:0]  op_address_sel;
  logic [31:0] lsu_wdata;
  logic        lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
  logic        data_gnt, data_rvalid;

  int          n_cmp = 0;
  int          n_err = 0;

  bit          pend = 1'b0;
  bit          inj_rvalid = 1'b0;
  bit          gnt_en = 1'b1;
  int          gnt_dly = 0;
  int          wcnt = 0;
  logic [31:0] rsp_data = 32'hDEADBEEF;
  logic [31:0] addr_log [$];

  bit          saw_req;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, got_done, got_err;
  logic [31:0] got_rdata;
  int          lat;

  mont_mul_lsu #(.ADDR_W(32), .REQ_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_sel         (cfg_sel),
    .cfg_wdata       (cfg_wdata),
    .lsu_ren         (lsu_ren),
    .lsu_wen         (lsu_wen),
    .lsu_type        (lsu_type),
    .lsu_addr_offset (lsu_addr_offset),
    .op_address_sel  (op_address_sel),
    .lsu_wdata       (lsu_wdata),
    .lsu_done        (lsu_done),
    .lsu_rdata       (lsu_rdata),
    .lsu_err         (lsu_err),
    .data_req        (data_req),
    .data_addr       (data_addr),
    .data_we         (data_we),
    .data_be         (data_be),
    .data_wdata      (data_wdata),
    .data_gnt        (data_gnt),
    .data_rvalid     (data_rvalid),
    .data_rdata      (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responder: grant after gnt_dly waiting cycles, rvalid in the cycle after grant.
  always @(negedge clk) begin
    data_rvalid = pend | inj_rvalid;
    data_rdata  = rsp_data;
    if (data_req && gnt_en) begin
      if (wcnt >= gnt_dly) data_gnt = 1'b1;
      else begin
        data_gnt = 1'b0;
        wcnt++;
      end
    end else begin
      data_gnt = 1'b0;
      wcnt     = 0;
    end
    pend = data_req && data_gnt;
    if (pend) addr_log.push_back(data_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [31:0] val);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = val;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Issue one request from an idle cycle and wait (bounded) for lsu_done.
  task automatic do_req(input logic w, input logic [1:0] ty, input logic [31:0] off,
                        input logic [1:0] sel, input logic [31:0] wd);
    repeat (2) @(negedge clk);
    lsu_wen = w; lsu_ren = !w; lsu_type = ty;
    lsu_addr_offset = off; op_address_sel = sel; lsu_wdata = wd;
    lat = 0; saw_req = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (data_req && !saw_req) begin
        saw_req = 1'b1;
        cap_addr = data_addr; cap_be = data_be; cap_we = data_we; cap_wdata = data_wdata;
      end
      if (lsu_done) break;
    end
    got_done = lsu_done; got_err = lsu_err; got_rdata = lsu_rdata;
    lsu_ren = 1'b0; lsu_wen = 1'b0;
  endtask

  initial begin
    int ndone;
    logic [31:0] off;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
    lsu_ren = 1'b0; lsu_wen = 1'b0; lsu_type = '0; lsu_addr_offset = '0;
    op_address_sel = '0; lsu_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", lsu_done, 0);
    chk("rst_req", data_req, 0);
    chk("rst_outs", {lsu_err, data_we, data_be, data_addr, lsu_rdata}, 0);
    rst = 1'b0;

    // Word read, immediate grant/response
    cfg(OPSEL_A, 32'h1000);
    do_req(1'b0, LSU_TYPE_WORD, 32'h8, OPSEL_A, 32'h0);
    chk("rd_addr", cap_addr, 32'h1008);
    chk("rd_be", cap_be, 4'b1111);
    chk("rd_we", cap_we, 0);
    chk("rd_lat", lat, 3);
    chk("rd_done", got_done, 1);
    chk("rd_rdata", got_rdata, 32'hDEADBEEF);
    chk("rd_err", got_err, 0);
    @(negedge clk);
    chk("rd_done_pulse", lsu_done, 0);

    // Byte write into lane 3
    cfg(OPSEL_RES, 32'h2000);
    do_req(1'b1, LSU_TYPE_BYTE, 32'h3, OPSEL_RES, 32'hA5);
    chk("wr_addr", cap_addr, 32'h2000);
    chk("wr_be", cap_be, 4'b1000);
    chk("wr_wdata", cap_wdata, 32'hA500_0000);
    chk("wr_we", cap_we, 1);
    chk("wr_lat", lat, 3);
    chk("wr_err", got_err, 0);

    // Misaligned half read
    do_req(1'b0, LSU_TYPE_HALF, 32'h1, OPSEL_A, 32'h0);
    chk("mis_noreq", saw_req, 0);
    chk("mis_lat", lat, 1);
    chk("mis_done_err", {got_done, got_err}, 2'b11);
    chk("mis_rdata", got_rdata, 0);
    @(negedge clk);
    chk("mis_err_pulse", lsu_err, 0);

    // Sub-word reads: extraction and lane enables
    do_req(1'b0, LSU_TYPE_HALF, 32'h6, OPSEL_A, 32'h0);
    chk("half_addr", cap_addr, 32'h1004);
    chk("half_be", cap_be, 4'b1100);
    chk("half_rdata", got_rdata, 32'h0000_DEAD);
    do_req(1'b0, LSU_TYPE_BYTE, 32'hD, OPSEL_A, 32'h0);
    chk("byte_addr", cap_addr, 32'h100C);
    chk("byte_be", cap_be, 4'b0010);
    chk("byte_rdata", got_rdata, 32'h0000_00BE);

    // Address wraps modulo 2^32
    cfg(OPSEL_N, 32'hFFFF_FFFC);
    do_req(1'b0, LSU_TYPE_WORD, 32'h8, OPSEL_N, 32'h0);
    chk("wrap_addr", cap_addr, 32'h4);
    chk("wrap_err", got_err, 0);

    // 12 back-to-back word reads, grant delayed 2 cycles
    cfg(OPSEL_B, 32'h3000);
    addr_log.delete();
    gnt_dly = 2;
    ndone = 0; off = 32'h0;
    lsu_type = LSU_TYPE_WORD; op_address_sel = OPSEL_B; lsu_addr_offset = off; lsu_ren = 1'b1;
    for (int c = 0; c < 400 && ndone < 12; c++) begin
      @(negedge clk);
      if (lsu_done) begin
        ndone++;
        off = off + 32'h4;
        lsu_addr_offset = off;
      end
    end
    lsu_ren = 1'b0;
    gnt_dly = 0;
    chk("b2b_done_cnt", ndone, 12);
    chk("b2b_req_cnt", addr_log.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < addr_log.size()) chk($sformatf("b2b_addr%0d", i), addr_log[i], 32'h3000 + 32'(4 * i));
    end

    // Timeout: no grant ever
    gnt_en = 1'b0;
    do_req(1'b0, LSU_TYPE_WORD, 32'h0, OPSEL_A, 32'h0);
    chk("tmo_saw_req", saw_req, 1);
    chk("tmo_lat", lat, 9);
    chk("tmo_done_err", {got_done, got_err}, 2'b11);
    chk("tmo_rdata", got_rdata, 0);
    @(negedge clk);
    chk("tmo_req_low", data_req, 0);
    gnt_en = 1'b1;

    // Reset while waiting for the response
    repeat (2) @(negedge clk);
    lsu_ren = 1'b1; lsu_type = LSU_TYPE_WORD; lsu_addr_offset = 32'h20; op_address_sel = OPSEL_A;
    @(negedge clk);
    chk("rstw_req", data_req, 1);
    @(negedge clk);
    rst = 1'b1; lsu_ren = 1'b0;
    #1;
    chk("rstw_req_low", data_req, 0);
    chk("rstw_done_low", lsu_done, 0);
    @(negedge clk);
    rst = 1'b0;
    // A stray rvalid while idle must not complete anything
    @(negedge clk); #1 inj_rvalid = 1'b1;
    @(negedge clk); #1 inj_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_done", lsu_done, 0);
    @(negedge clk);
    chk("late_rvalid_done2", lsu_done, 0);
    // Base registers were cleared by reset
    do_req(1'b0, LSU_TYPE_WORD, 32'h40, OPSEL_A, 32'h0);
    chk("post_rst_addr", cap_addr, 32'h40);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", got_rdata, 32'hDEADBEEF);
    chk("post_rst_err", got_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
